// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the receiver and the transmitter:
//   - default timing parameters (OVERSAMPLE_DEF, SAMPLE_PT_DEF, DATA_BITS_DEF)
//   - idle line level (LINE_IDLE)
//   - receiver state enumeration (uart_state_e)
// Optional feature macro: UART_RX_PARITY_EN adds the ST_PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   OVERSAMPLE_DEF = 16;   // uart_clk cycles per bit period
    localparam int   SAMPLE_PT_DEF  = 7;    // mid-bit sample point
    localparam int   DATA_BITS_DEF  = 8;    // data bits per frame
    localparam logic LINE_IDLE      = 1'b1; // serial line level when idle

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Receiver-to-FIFO write bus plus receiver status.
//   wr_req     : one-cycle FIFO write strobe              (receiver -> FIFO)
//   wr_data    : received byte, held until next write     (receiver -> FIFO)
//   wr_full    : downstream FIFO full                     (FIFO -> receiver)
//   frame_err  : one-cycle pulse, stop bit sampled low    (receiver -> system)
//   overrun    : one-cycle pulse, good frame dropped      (receiver -> system)
//   busy       : receiver not idle                        (receiver -> system)
//   parity_err : one-cycle pulse, only with UART_RX_PARITY_EN defined
// Modports: master = receiver side, slave = FIFO / system side.
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);

    logic                 wr_req;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_full;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output wr_req,
        output wr_data,
        output frame_err,
        output overrun,
        output busy,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        input  wr_full
    );

    modport slave (
        input  wr_req,
        input  wr_data,
        input  frame_err,
        input  overrun,
        input  busy,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        output wr_full
    );

endinterface

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// the idle line level so a reset never looks like a start bit.
//   uart_clk : receive clock
//   rst_n    : asynchronous active-low reset
//   d        : asynchronous input
//   q        : synchronized output
// -----------------------------------------------------------------------------
module uart_sync2
    import uart_pkg::*;
(
    input  logic uart_clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage resynchronization of d into the uart_clk domain
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= LINE_IDLE;
            sync_r <= LINE_IDLE;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Oversampling UART receiver that writes each good frame into a downstream
// FIFO. Frame = start + DATA_BITS (LSB first) [+ even parity] + stop.
// Ports:
//   uart_clk : receive clock, OVERSAMPLE x baud
//   rst_n    : asynchronous active-low reset
//   rxd      : serial line, asynchronous, idle high
//   wr_if    : uart_rx_fifo_if.master (wr_req, wr_data, wr_full, frame_err,
//              overrun, busy, and parity_err when enabled)
// Optional feature macro: UART_RX_PARITY_EN (parity bit after the data bits).
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int SAMPLE_PT  = SAMPLE_PT_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic           uart_clk,
    input  logic           rst_n,
    input  logic           rxd,
    uart_rx_fifo_if.master wr_if
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    // Frame bit index: 0 = start, 1..DATA_BITS = data, then parity/stop
    localparam int IDX_W = $clog2(DATA_BITS + 3);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST_D = IDX_W'(DATA_BITS);

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit equals the XOR of all data bits
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction
`endif

    logic                 rxd_s;
    logic                 rxd_d_r;
    logic [1:0]           settle_r;
    logic                 start_edge_s;
    logic                 sample_s;
    logic                 wrap_s;
    uart_state_e          state_r, state_n;
    logic [CNT_W-1:0]     cnt_r, cnt_n;
    logic [IDX_W-1:0]     idx_r, idx_n;
    logic [DATA_BITS-1:0] shift_r, shift_n;
    logic [DATA_BITS-1:0] wr_data_r, wr_data_n;
    logic                 wr_req_r, wr_req_n;
    logic                 frame_err_r, frame_err_n;
    logic                 overrun_r, overrun_n;
    logic                 busy_r;
    logic                 par_ok_r, par_ok_n;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_r, parity_err_n;
`endif

    uart_sync2 u_sync (
        .uart_clk (uart_clk),
        .rst_n    (rst_n),
        .d        (rxd),
        .q        (rxd_s)
    );

    // Event decode. Edges are ignored until the synchronizer and rxd_d_r hold
    // real line samples, so a line already low at reset release is not a start.
    always_comb begin
        start_edge_s = (settle_r == 2'd3) && rxd_d_r && !rxd_s;
        sample_s     = (cnt_r == CNT_SAMPLE);
        wrap_s       = (cnt_r == CNT_LAST);
    end

    // Next-state, bit timing, shift register and output pulse decode
    always_comb begin
        state_n     = state_r;
        cnt_n       = wrap_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        idx_n       = wrap_s ? (idx_r + IDX_ONE) : idx_r;
        shift_n     = shift_r;
        wr_data_n   = wr_data_r;
        wr_req_n    = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
        par_ok_n    = par_ok_r;
`ifdef UART_RX_PARITY_EN
        parity_err_n = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                cnt_n    = CNT_ZERO;
                idx_n    = IDX_ZERO;
                par_ok_n = 1'b1;
                if (start_edge_s) begin
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_s) begin
                    if (!rxd_s) begin
                        state_n = ST_DATA;
                    end else begin
                        // Start bit gone by mid-bit: a glitch, not a frame
                        state_n = ST_IDLE;
                        cnt_n   = CNT_ZERO;
                        idx_n   = IDX_ZERO;
                    end
                end else begin
                    state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s) begin
                    // Right shift: the first (LSB) bit ends up in bit 0
                    shift_n = {rxd_s, shift_r[DATA_BITS-1:1]};
                    if (idx_r == IDX_LAST_D) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample_s) begin
                    par_ok_n = (rxd_s == even_parity(shift_r));
                    state_n  = ST_STOP;
                end else begin
                    state_n  = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (sample_s) begin
                    // Leaving at mid-stop lets a back-to-back start be seen
                    cnt_n = CNT_ZERO;
                    idx_n = IDX_ZERO;
                    if (!rxd_s) begin
                        frame_err_n = 1'b1;
                        state_n     = ST_BREAK;
                    end else if (!par_ok_r) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_n = 1'b1;
`endif
                        state_n = ST_IDLE;
                    end else if (wr_if.wr_full) begin
                        overrun_n = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        wr_req_n  = 1'b1;
                        wr_data_n = shift_r;
                        state_n   = ST_IDLE;
                    end
                end else begin
                    state_n = ST_STOP;
                end
            end
            ST_BREAK: begin
                cnt_n = CNT_ZERO;
                idx_n = IDX_ZERO;
                if (rxd_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_BREAK;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = CNT_ZERO;
                idx_n   = IDX_ZERO;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= IDX_ZERO;
            shift_r     <= {DATA_BITS{1'b0}};
            wr_data_r   <= {DATA_BITS{1'b0}};
            wr_req_r    <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
            par_ok_r    <= 1'b1;
            rxd_d_r     <= LINE_IDLE;
            settle_r    <= 2'd0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            idx_r       <= idx_n;
            shift_r     <= shift_n;
            wr_data_r   <= wr_data_n;
            wr_req_r    <= wr_req_n;
            frame_err_r <= frame_err_n;
            overrun_r   <= overrun_n;
            busy_r      <= (state_n != ST_IDLE);
            par_ok_r    <= par_ok_n;
            rxd_d_r     <= rxd_s;
            settle_r    <= (settle_r == 2'd3) ? settle_r : (settle_r + 2'd1);
`ifdef UART_RX_PARITY_EN
            parity_err_r <= parity_err_n;
`endif
        end
    end

    assign wr_if.wr_req    = wr_req_r;
    assign wr_if.wr_data   = wr_data_r;
    assign wr_if.frame_err = frame_err_r;
    assign wr_if.overrun   = overrun_r;
    assign wr_if.busy      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign wr_if.parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. Frames are serialized bit by bit at
// 16 clocks per bit; an outcome list is predicted from the frame contents,
// stop-bit level and wr_full, and compared with the pulses seen on the bus.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int BIT_T = 16;
    localparam int K_WR  = 0;
    localparam int K_FE  = 1;
    localparam int K_OV  = 2;
    localparam int K_PE  = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    logic rxd;
    int   cyc;
    int   total;
    int   bad;
    int   excl_viol;
    int   width_viol;
    logic prev_req, prev_fe, prev_ov;
    ev_t  obs_q[$];
    ev_t  exp_q[$];

    uart_rx_fifo_if #(.DATA_BITS(8)) wr_if ();

    uart_rx_fifo dut (
        .uart_clk (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .wr_if    (wr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus monitor: records output pulses and checks exclusivity / width
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req <= 1'b0;
            prev_fe  <= 1'b0;
            prev_ov  <= 1'b0;
        end else begin
            if ((32'(wr_if.wr_req) + 32'(wr_if.frame_err) + 32'(wr_if.overrun)) > 32'd1)
                excl_viol <= excl_viol + 1;
            if ((wr_if.wr_req && prev_req) || (wr_if.frame_err && prev_fe) ||
                (wr_if.overrun && prev_ov))
                width_viol <= width_viol + 1;
            if (wr_if.wr_req)    obs_q.push_back('{K_WR, wr_if.wr_data, cyc});
            if (wr_if.frame_err) obs_q.push_back('{K_FE, 8'h00, cyc});
            if (wr_if.overrun)   obs_q.push_back('{K_OV, 8'h00, cyc});
`ifdef UART_RX_PARITY_EN
            if (wr_if.parity_err) obs_q.push_back('{K_PE, 8'h00, cyc});
`endif
            prev_req <= wr_if.wr_req;
            prev_fe  <= wr_if.frame_err;
            prev_ov  <= wr_if.overrun;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Serialize one frame; stop_low > 0 holds the stop bit low that many bit
    // times and returns with the line just released high.
    task automatic send_frame(input logic [7:0] d, input int stop_low, output int t_fall);
        t_fall = cyc;
        rxd = 1'b0;
        hold(BIT_T);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            hold(BIT_T);
        end
`ifdef UART_RX_PARITY_EN
        rxd = ^d;
        hold(BIT_T);
`endif
        if (stop_low > 0) begin
            rxd = 1'b0;
            hold(BIT_T * stop_low);
            rxd = 1'b1;
            exp_q.push_back('{K_FE, 8'h00, 0});
        end else begin
            rxd = 1'b1;
            hold(BIT_T);
            if (wr_if.wr_full) exp_q.push_back('{K_OV, 8'h00, 0});
            else               exp_q.push_back('{K_WR, d, 0});
        end
    endtask

    task automatic check_events(input string tag);
        int n;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
            chk({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int t0;
        int lat;
        logic [7:0] d;
        int r;
        int stop_low;

        cyc = 0; total = 0; bad = 0; excl_viol = 0; width_viol = 0;
        rxd = 1'b1;
        wr_if.wr_full = 1'b0;
        rst_n = 1'b0;
        hold(3);
        chk("rst_busy",   32'(wr_if.busy), 32'd0);
        chk("rst_wr_req", 32'(wr_if.wr_req), 32'd0);
        chk("rst_data",   32'(wr_if.wr_data), 32'd0);
        rst_n = 1'b1;
        hold(8);

        // Single frame 0x55, latency about 9.5 bit times
        send_frame(8'h55, 0, t0);
        hold(40);
        lat = (obs_q.size() > 0) ? (obs_q[0].cyc - t0) : -1;
        chk("lat_0x55", 32'((lat >= 9 * BIT_T) && (lat <= 10 * BIT_T + 8)), 32'd1);
        check_events("f55");

        // Back-to-back frames, zero idle
        send_frame(8'hA3, 0, t0);
        send_frame(8'h0F, 0, t0);
        hold(40);
        check_events("b2b");

        // 4-cycle glitch on the line
        rxd = 1'b0;
        hold(4);
        chk("glitch_busy_hi", 32'(wr_if.busy), 32'd1);
        rxd = 1'b1;
        hold(10);
        chk("glitch_busy_lo", 32'(wr_if.busy), 32'd0);
        hold(30);
        check_events("glitch");

        // Stop bit held low for 3 bit times
        send_frame(8'h81, 3, t0);
        chk("break_busy_hi", 32'(wr_if.busy), 32'd1);
        hold(6);
        chk("break_busy_lo", 32'(wr_if.busy), 32'd0);
        hold(20);
        check_events("break");

        // Overrun, then a good frame
        wr_if.wr_full = 1'b1;
        send_frame(8'h3C, 0, t0);
        wr_if.wr_full = 1'b0;
        send_frame(8'h3D, 0, t0);
        hold(40);
        check_events("overrun");

        // Reset during data bit 4 of 0xFF
        rxd = 1'b0;
        hold(BIT_T);
        rxd = 1'b1;
        hold(4 * BIT_T + 8);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_req", 32'(wr_if.wr_req), 32'd0);
        chk("mid_rst_fe",     32'(wr_if.frame_err), 32'd0);
        chk("mid_rst_ov",     32'(wr_if.overrun), 32'd0);
        chk("mid_rst_busy",   32'(wr_if.busy), 32'd0);
        chk("mid_rst_data",   32'(wr_if.wr_data), 32'd0);
        hold(3);
        rst_n = 1'b1;
        hold(6 * BIT_T);
        send_frame(8'h12, 0, t0);
        hold(40);
        check_events("post_rst");

        // Randomized frames: random data, occasional full FIFO or break
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 7);
            wr_if.wr_full = (r == 0);
            stop_low = (r == 1) ? 2 : 0;
            send_frame(d, stop_low, t0);
            if (stop_low > 0) hold(8 + $urandom_range(0, 5));
            else              hold($urandom_range(0, 12));
        end
        wr_if.wr_full = 1'b0;
        hold(40);
        check_events("random");

        chk("exclusive_pulses", 32'(excl_viol), 32'd0);
        chk("single_cycle_pulses", 32'(width_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: OVERSAMPLE, 16, uart_clk cycles per bit period.
REQ-002 Parameter: SAMPLE_PT, 7, counter value within a bit at which rxd is sampled (mid-bit).
REQ-003 Parameter: DATA_BITS, 8, data bits per frame, LSB first.
REQ-004 Port: uart_clk  input  1  receive clock, OVERSAMPLE x baud.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: rxd  input  1  serial line, asynchronous to uart_clk, idle high.
REQ-007 Port: wr_full  input  1  downstream FIFO full.
REQ-008 Port: wr_req  output  1  one-cycle FIFO write strobe.
REQ-009 Port: wr_data  output  DATA_BITS  received byte, valid while wr_req=1 and held until the next write.
REQ-010 Port: frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 Port: overrun  output  1  one-cycle pulse, good frame dropped because wr_full=1.
REQ-012 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value rxd_s.
REQ-014 States SHALL be IDLE, START, DATA, STOP, BREAK (plus PARITY when configured).
REQ-015 IDLE: on a 1->0 transition of rxd_s, SHALL go to START with bit counter cnt=0.
REQ-016 cnt SHALL count 0..OVERSAMPLE-1 and wrap to 0; a bit index SHALL advance on each wrap.
REQ-017 START: at cnt=SAMPLE_PT, rxd_s=0 SHALL go to DATA; rxd_s=1 SHALL be treated as a glitch and return to IDLE with no output.
REQ-018 DATA: rxd_s SHALL be sampled at cnt=SAMPLE_PT into shift register bit 0..DATA_BITS-1 in order; after the last bit, SHALL go to STOP.
REQ-019 STOP: at cnt=SAMPLE_PT: rxd_s=1 and wr_full=0 -> wr_req=1 next cycle, wr_data=shift register, go to IDLE.
REQ-020 STOP: rxd_s=1 and wr_full=1 -> overrun=1 for one cycle, no wr_req, go to IDLE.
REQ-021 STOP: rxd_s=0 -> frame_err=1 for one cycle, no wr_req, go to BREAK.
REQ-022 BREAK: SHALL stay until rxd_s=1, then go to IDLE; no start detection while in BREAK.
REQ-023 Return to IDLE at mid-stop-bit SHALL allow a back-to-back start bit to be detected with zero idle time.
REQ-024 wr_req, frame_err and overrun SHALL be mutually exclusive and never high for more than one cycle.
REQ-025 wr_full SHALL be evaluated only in the stop-sample cycle.

Reset
REQ-026 Assertion of rst_n SHALL immediately force: state=IDLE, cnt=0, shift register=0, wr_data=0, wr_req=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, reception SHALL resume only on a fresh 1->0 edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state SHALL follow DATA; the sampled bit is even parity over the data; a mismatch SHALL add output parity_err (one-cycle pulse at the stop sample), with the frame dropped (no wr_req).
REQ-029 Macro UART_RX_PARITY_EN undefined: no PARITY state, no parity_err port, and frame = start + DATA_BITS + stop.

Structure
REQ-030 Package uart_pkg SHALL hold the state enumeration, the OVERSAMPLE/SAMPLE_PT defaults, and the idle line level constant, shared with the transmitter.
REQ-031 Sub-module uart_sync2 (2-flop synchronizer, reset value 1) SHALL be instantiated for rxd; all other logic stays in uart_rx_fifo.

Verification
REQ-032 Frame 0x55 at 16x, wr_full=0 -> single wr_req with wr_data=0x55, about 9.5 bit times after the start edge.
REQ-033 Back-to-back frames 0xA3 then 0x0F, no idle gap -> two wr_req pulses, data 0xA3 then 0x0F.
REQ-034 rxd low pulse of 4 uart_clk cycles -> no output, busy returns low by cycle 10.
REQ-035 Frame 0x81 with stop bit held low for 3 bit times -> frame_err pulse, no wr_req, busy high until rxd returns high.
REQ-036 Frame 0x3C with wr_full=1 -> overrun pulse, no wr_req; next frame 0x3D with wr_full=0 -> wr_data=0x3D.
REQ-037 rst_n asserted at data bit 4 of frame 0xFF -> all outputs 0 immediately; following frame 0x12 is received correctly.
